// File: rtl/expr_pkg.sv
//------------------------------------------------------------------------------
// expr_pkg : shared constants, term record and FSM encoding for expr_tx
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  localparam logic [1:0] OP_PLUS = 2'b01;
  localparam logic [1:0] OP_STAR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_OP    = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] digit;
    logic [1:0] op;
    logic       last;
  } term_t;

  // The operator of a final term is never emitted, so it is not checked.
  function automatic logic term_legal(input logic [3:0] digit,
                                      input logic [1:0] op,
                                      input logic       last);
    return (digit <= 4'd9) && (last || op == OP_PLUS || op == OP_STAR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/term_fifo.sv
//------------------------------------------------------------------------------
// term_fifo : DEPTH-entry synchronous FIFO of term records, full/empty flags
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module term_fifo
  import expr_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  clr_n,
  input  logic  wr_en_i,
  input  term_t wr_data_i,
  input  logic  rd_en_i,
  output term_t rd_data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  term_t          mem_q [DEPTH];
  logic  [AW:0]   wr_ptr_q;
  logic  [AW:0]   rd_ptr_q;
  logic           wr_fire;
  logic           rd_fire;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = rd_en_i && !empty_o;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (rd_fire) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/expr_tx.sv
//------------------------------------------------------------------------------
// expr_tx : term legality filter, term FIFO and ASCII expression serializer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module expr_tx
  import expr_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       term_valid,
  output logic       term_ready,
  input  logic [3:0] term_digit,
  input  logic [1:0] term_op,
  input  logic       term_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       out_last,
  output logic       err,
  output logic [7:0] expr_cnt
);

  state_e     state_q, state_d;
  logic [7:0] expr_cnt_q;
  logic       err_q;

  term_t      head;
  term_t      wr_term;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       term_fire;
  logic       term_ok;
  logic       expr_done;

  assign term_ready = !fifo_full;
  assign term_fire  = term_valid && term_ready;
  assign term_ok    = term_legal(term_digit, term_op, term_last);
  assign wr_term    = '{digit: term_digit, op: term_op, last: term_last};

  term_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr_n     (clr_n),
    .wr_en_i   (term_fire && term_ok),
    .wr_data_i (wr_term),
    .rd_en_i   (fifo_rd),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      expr_cnt_q <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= term_fire && !term_ok;
      if (expr_done) expr_cnt_q <= expr_cnt_q + 8'h01;
    end
  end

  // A term stays at the head through both its digit and operator bytes;
  // it is popped only once the operator (or a final digit) is accepted.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    fifo_rd   = 1'b0;
    expr_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_DIGIT;
      end
      S_DIGIT: begin
        if (!fifo_empty) begin
          out_valid = 1'b1;
          out_char  = CH_ZERO + {4'h0, head.digit};
          out_last  = head.last;
          if (out_ready) begin
            if (head.last) begin
              fifo_rd   = 1'b1;
              expr_done = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_OP;
            end
          end
        end
      end
      S_OP: begin
        out_valid = 1'b1;
        out_char  = (head.op == OP_STAR) ? CH_STAR : CH_PLUS;
        if (out_ready) begin
          fifo_rd = 1'b1;
          state_d = S_DIGIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err      = err_q;
  assign expr_cnt = expr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_expr_tx.sv
//------------------------------------------------------------------------------
// tb_expr_tx : directed self-checking bench for expr_tx
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_expr_tx;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       term_valid;
  logic       term_ready;
  logic [3:0] term_digit;
  logic [1:0] term_op;
  logic       term_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic       out_last;
  logic       err;
  logic [7:0] expr_cnt;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int err_seen  = 0;

  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];

  expr_tx #(.DEPTH(4)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .term_valid (term_valid),
    .term_ready (term_ready),
    .term_digit (term_digit),
    .term_op    (term_op),
    .term_last  (term_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_char   (out_char),
    .out_last   (out_last),
    .err        (err),
    .expr_cnt   (expr_cnt)
  );

  always #5 clk = ~clk;

  // Inputs only change 1 time unit after a rising edge, so a handshake seen
  // at the falling edge is the one that completes at the next rising edge.
  always @(negedge clk) begin
    if (clr_n) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_char});
      if (err) err_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("%s_byte%0d", tag, i),
            (i < got_q.size()) ? {23'h0, got_q[i]} : 32'hFFFF_FFFF,
            {23'h0, exp_q[i]});
  endtask

  task automatic push(input logic [3:0] d, input logic [1:0] op, input logic last);
    int waited = 0;
    term_valid = 1'b1;
    term_digit = d;
    term_op    = op;
    term_last  = last;
    while (!term_ready && waited < 50) begin
      tick(1);
      waited++;
    end
    check("push_ready", {31'h0, term_ready}, 32'h1);
    tick(1);
    term_valid = 1'b0;
    term_digit = 4'h0;
    term_op    = 2'b00;
    term_last  = 1'b0;
  endtask

  // Grammar digit ( ('+'|'*') digit )*, with out_last only on the final digit.
  function automatic logic stream_ok();
    logic [1:0] st = 2'd0;
    logic [7:0] c;
    logic       dig;
    foreach (got_q[i]) begin
      c   = got_q[i][7:0];
      dig = (c >= 8'h30) && (c <= 8'h39);
      if (dig && st != 2'd1) st = 2'd1;
      else if ((c == 8'h2B || c == 8'h2A) && st == 2'd1) st = 2'd2;
      else return 1'b0;
      if (got_q[i][8] != ((i == got_q.size() - 1) && dig)) return 1'b0;
    end
    return (st == 2'd1);
  endfunction

  initial begin
    clr_n      = 1'b0;
    term_valid = 1'b0;
    term_digit = 4'h0;
    term_op    = 2'b00;
    term_last  = 1'b0;
    out_ready  = 1'b0;
    tick(2);

    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_char", {24'h0, out_char}, 32'h00);
    check("rst_out_last", {31'h0, out_last}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_expr_cnt", {24'h0, expr_cnt}, 32'h0);
    check("rst_term_ready", {31'h0, term_ready}, 32'h1);
    clr_n = 1'b1;
    tick(1);

    // Single final term and first-byte latency
    got_q.delete();
    out_ready = 1'b1;
    push(4'd7, 2'b00, 1'b1);
    check("t1_idle_after_write", {31'h0, out_valid}, 32'h0);
    tick(1);
    check("t1_valid", {31'h0, out_valid}, 32'h1);
    check("t1_char", {24'h0, out_char}, 32'h37);
    check("t1_last", {31'h0, out_last}, 32'h1);
    tick(4);
    exp_q = '{9'h137};
    check_stream("t1");
    check("t1_expr_cnt", {24'h0, expr_cnt}, 32'd1);

    // 1+2*3 streaming
    got_q.delete();
    push(4'd1, 2'b01, 1'b0);
    push(4'd2, 2'b10, 1'b0);
    push(4'd3, 2'b00, 1'b1);
    tick(10);
    exp_q = '{9'h031, 9'h02B, 9'h032, 9'h02A, 9'h133};
    check_stream("t2");
    check("t2_grammar", {31'h0, stream_ok()}, 32'h1);
    check("t2_expr_cnt", {24'h0, expr_cnt}, 32'd2);

    // Fill with out_ready low, hold off a fifth term, then drain
    got_q.delete();
    out_ready = 1'b0;
    push(4'd1, 2'b01, 1'b0);
    push(4'd2, 2'b10, 1'b0);
    push(4'd3, 2'b01, 1'b0);
    push(4'd4, 2'b00, 1'b1);
    check("t3_full", {31'h0, term_ready}, 32'h0);
    term_valid = 1'b1;
    term_digit = 4'd9;
    term_op    = 2'b00;
    term_last  = 1'b1;
    tick(3);
    check("t3_held_ready", {31'h0, term_ready}, 32'h0);
    check("t3_hold_valid", {31'h0, out_valid}, 32'h1);
    check("t3_hold_char", {24'h0, out_char}, 32'h31);
    check("t3_hold_last", {31'h0, out_last}, 32'h0);
    term_valid = 1'b0;
    term_last  = 1'b0;
    term_digit = 4'h0;
    out_ready  = 1'b1;
    tick(12);
    exp_q = '{9'h031, 9'h02B, 9'h032, 9'h02A, 9'h033, 9'h02B, 9'h134};
    check_stream("t3");
    check("t3_grammar", {31'h0, stream_ok()}, 32'h1);
    check("t3_expr_cnt", {24'h0, expr_cnt}, 32'd3);
    check("t3_drained", {31'h0, out_valid}, 32'h0);

    // Illegal terms are consumed and flagged
    got_q.delete();
    err_seen = 0;
    push(4'd12, 2'b01, 1'b0);
    check("t4_err_pulse_a", {31'h0, err}, 32'h1);
    tick(1);
    check("t4_err_clear_a", {31'h0, err}, 32'h0);
    push(4'd4, 2'b11, 1'b0);
    check("t4_err_pulse_b", {31'h0, err}, 32'h1);
    tick(1);
    check("t4_err_clear_b", {31'h0, err}, 32'h0);
    tick(3);
    check("t4_err_count", err_seen, 32'd2);
    check("t4_no_bytes", got_q.size(), 32'd0);
    check("t4_no_valid", {31'h0, out_valid}, 32'h0);
    check("t4_ready", {31'h0, term_ready}, 32'h1);
    check("t4_expr_cnt", {24'h0, expr_cnt}, 32'd3);

    // Starved after an operator: no byte until the next term arrives
    got_q.delete();
    push(4'd5, 2'b01, 1'b0);
    tick(10);
    exp_q = '{9'h035, 9'h02B};
    check_stream("t5_gap");
    check("t5_gap_valid", {31'h0, out_valid}, 32'h0);
    push(4'd6, 2'b00, 1'b1);
    tick(5);
    exp_q = '{9'h035, 9'h02B, 9'h136};
    check_stream("t5");
    check("t5_expr_cnt", {24'h0, expr_cnt}, 32'd4);

    // Reset in the middle of an expression
    got_q.delete();
    out_ready = 1'b0;
    push(4'd1, 2'b01, 1'b0);
    push(4'd2, 2'b10, 1'b0);
    push(4'd3, 2'b00, 1'b1);
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0;
    exp_q = '{9'h031, 9'h02B};
    check_stream("t6_pre");
    clr_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'h0, out_valid}, 32'h0);
    check("t6_rst_char", {24'h0, out_char}, 32'h00);
    check("t6_rst_last", {31'h0, out_last}, 32'h0);
    check("t6_rst_expr_cnt", {24'h0, expr_cnt}, 32'h0);
    check("t6_rst_ready", {31'h0, term_ready}, 32'h1);
    tick(2);
    clr_n = 1'b1;
    got_q.delete();
    out_ready = 1'b1;
    tick(8);
    check("t6_no_bytes", got_q.size(), 32'd0);
    check("t6_idle", {31'h0, out_valid}, 32'h0);
    check("t6_expr_cnt", {24'h0, expr_cnt}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
